aidc_lite_decomp_sr: RTL and testbench

Sign-reduction decompressor for the AIDC-Lite datapath; the inverse of the SR compressor stage. It consumes a packet of sixteen 64-bit compressed words and re-expands every word into two 64-bit raw beats of four 16-bit sign-extended lanes, producing the 32-beat packet that the compressor originally consumed. It sits downstream of the compressed-line storage, on the read/fill path.

---
 rtl/aidc_lite_pkg.sv | 23 ++
 rtl/aidc_lite_sr_expand.sv | 27 ++
 rtl/aidc_lite_decomp_sr.sv | 127 ++++++++++++
 tb/tb_aidc_lite_decomp_sr.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the AIDC-Lite sign-reduction datapath.
package aidc_lite_pkg;

  localparam int unsigned AIDC_LITE_WORDS_PER_PKT = 16;
  localparam int unsigned AIDC_LITE_BEATS_PER_PKT = 32;
  localparam int unsigned AIDC_LITE_LANE_W        = 16;
  localparam int unsigned AIDC_LITE_CODE_W        = 8;
  localparam int unsigned AIDC_LITE_HDR_CODE_W    = 7;
  localparam int unsigned AIDC_LITE_MARKER_BIT    = 63;

  localparam int unsigned AIDC_LITE_WORD_W        = 64;
  localparam int unsigned AIDC_LITE_HALF_W        = AIDC_LITE_WORD_W / 2;
  localparam int unsigned AIDC_LITE_LANES         = AIDC_LITE_WORD_W / AIDC_LITE_LANE_W;
  localparam int unsigned AIDC_LITE_CNT_W         = 4;

  // Holding-register occupancy: EMPTY, upper half pending, lower half pending.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_UPPER = 2'd1,
    ST_LOWER = 2'd2
  } sr_state_e;

endpackage

// File: rtl/aidc_lite_sr_expand.sv
// Expands one 32-bit compressed half into a 64-bit beat of four sign-extended
// 16-bit lanes. With first_i set, lane 3 is the 7-bit header code (bit 31 is
// the compressed-marker flag and is not part of the lane value).
module aidc_lite_sr_expand
  import aidc_lite_pkg::*;
(
  input  logic [AIDC_LITE_HALF_W-1:0] half_i,
  input  logic                        first_i,
  output logic [AIDC_LITE_WORD_W-1:0] beat_o
);

  // Per-lane sign extension, header lane override for beat 0.
  always_comb begin
    beat_o = '0;
    for (int unsigned i = 0; i < AIDC_LITE_LANES; i++) begin
      beat_o[i*AIDC_LITE_LANE_W +: AIDC_LITE_LANE_W] =
        {{(AIDC_LITE_LANE_W-AIDC_LITE_CODE_W){half_i[i*AIDC_LITE_CODE_W + AIDC_LITE_CODE_W-1]}},
         half_i[i*AIDC_LITE_CODE_W +: AIDC_LITE_CODE_W]};
    end
    if (first_i) begin
      beat_o[AIDC_LITE_WORD_W-1 -: AIDC_LITE_LANE_W] =
        {{(AIDC_LITE_LANE_W-AIDC_LITE_HDR_CODE_W){half_i[AIDC_LITE_HALF_W-2]}},
         half_i[AIDC_LITE_HALF_W-2 -: AIDC_LITE_HDR_CODE_W]};
    end
  end

endmodule

// File: rtl/aidc_lite_decomp_sr.sv
// Sign-reduction decompressor: 16 compressed words in, 32 raw beats out.
// One holding register; each held word is emitted as its upper then lower beat.
module aidc_lite_decomp_sr
  import aidc_lite_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        sop_i,
  input  logic                        eop_i,
  input  logic [AIDC_LITE_WORD_W-1:0] data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        sop_o,
  output logic                        eop_o,
  output logic [AIDC_LITE_WORD_W-1:0] data_o,
  output logic                        err_o
);

  sr_state_e                   state_q, state_d;
  logic [AIDC_LITE_WORD_W-1:0] data_q, data_d;
  logic                        sop_q, sop_d;
  logic                        eop_q, eop_d;
  logic                        err_q, err_d;
  logic [AIDC_LITE_CNT_W-1:0]  cnt_q, cnt_d;
  logic                        in_pkt_q, in_pkt_d;
  logic                        err_acc_q, err_acc_d;

  logic                        full;
  logic                        half;
  logic                        accept;
  logic                        load;
  logic                        take;
  logic                        word_err;
  logic [AIDC_LITE_HALF_W-1:0] half_sel;

  assign full    = (state_q != ST_EMPTY);
  assign half    = (state_q == ST_LOWER);
  assign ready_o = !full | (half & ready_i);
  assign accept  = valid_i & ready_o;
  // Non-sop words outside a packet are accepted but never loaded.
  assign load    = accept & (sop_i | in_pkt_q);
  assign take    = full & ready_i;

  // Packet tracking: word count, in-packet flag and accumulated error.
  always_comb begin
    cnt_d     = cnt_q;
    in_pkt_d  = in_pkt_q;
    err_acc_d = err_acc_q;
    word_err  = 1'b0;
    if (load) begin
      if (sop_i) begin
        cnt_d     = AIDC_LITE_CNT_W'(1);
        in_pkt_d  = 1'b1;
        // A sop that interrupts an open packet taints the new packet.
        err_acc_d = in_pkt_q | ~data_i[AIDC_LITE_MARKER_BIT];
        word_err  = 1'b1;
      end else begin
        cnt_d    = cnt_q + AIDC_LITE_CNT_W'(1);
        word_err = err_acc_q | (cnt_q != AIDC_LITE_CNT_W'(AIDC_LITE_WORDS_PER_PKT-1));
      end
      if (eop_i) begin
        in_pkt_d = 1'b0;
      end
    end
  end

  // Holding register occupancy and contents.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = err_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_UPPER;
      ST_UPPER: if (take) state_d = ST_LOWER;
      ST_LOWER: if (take) state_d = load ? ST_UPPER : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (load) begin
      data_d = data_i;
      sop_d  = sop_i;
      eop_d  = eop_i;
      err_d  = eop_i & word_err;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      in_pkt_q  <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      in_pkt_q  <= in_pkt_d;
      err_acc_q <= err_acc_d;
    end
  end

  assign half_sel = half ? data_q[AIDC_LITE_HALF_W-1:0]
                         : data_q[AIDC_LITE_WORD_W-1:AIDC_LITE_HALF_W];

  aidc_lite_sr_expand u_expand (
    .half_i  (half_sel),
    .first_i (sop_q & !half),
    .beat_o  (data_o)
  );

  assign valid_o = full;
  assign sop_o   = full & sop_q & !half;
  assign eop_o   = full & eop_q & half;
  assign err_o   = eop_o & err_q;

endmodule

// File: tb/tb_aidc_lite_decomp_sr.sv
// Randomized bench for aidc_lite_decomp_sr against a packet-level reference model.
module tb_aidc_lite_decomp_sr;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, sop_i, eop_i;
  logic [63:0] data_i;
  logic        valid_o, ready_i, sop_o, eop_o, err_o;
  logic [63:0] data_o;

  aidc_lite_decomp_sr dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sop_i   (sop_i),
    .eop_i   (eop_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sop_o   (sop_o),
    .eop_o   (eop_o),
    .data_o  (data_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  typedef struct {
    logic [63:0] w;
    logic        sop;
    logic        eop;
  } word_t;

  beat_t       exp_q[$];
  word_t       stim_q[$];
  beat_t       got_log[$];
  int          got_cyc[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          vld_pct  = 100;
  int          rdy_pct  = 100;
  int          cyc      = 0;
  bit          m_in_pkt = 0;
  bit          m_err    = 0;
  int          m_idx    = 0;
  bit          stalled_prev = 0;
  logic [63:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Lane value as plain signed arithmetic on the code.
  function automatic logic [63:0] exp_beat(input logic [31:0] h, input bit first);
    logic [63:0] r;
    int          v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = int'(h[8*k +: 8]);
      if (v > 127) v -= 256;
      if (first && k == 3) begin
        v = int'(h[30:24]);
        if (v > 63) v -= 128;
      end
      r[16*k +: 16] = 16'(v);
    end
    return r;
  endfunction

  function automatic void model_accept(input word_t wd);
    bit perr;
    if (!wd.sop && !m_in_pkt) return;
    if (wd.sop) begin
      m_err    = m_in_pkt ? 1'b1 : !wd.w[63];
      m_idx    = 0;
      m_in_pkt = 1;
    end else begin
      m_idx = (m_idx + 1) % 16;
    end
    perr = wd.eop && (m_err || m_idx != 15);
    if (wd.eop) m_in_pkt = 0;
    exp_q.push_back('{exp_beat(wd.w[63:32], wd.sop), wd.sop, 1'b0, 1'b0});
    exp_q.push_back('{exp_beat(wd.w[31:0], 1'b0), 1'b0, wd.eop, perr});
  endfunction

  // One clock: drive at negedge, sample 1 unit later, advance the model.
  task automatic step(input bit do_rst);
    bit    exp_rdy, take, acc;
    beat_t e;
    @(negedge clk);
    rst     = do_rst;
    valid_i = (stim_q.size() > 0) && ($urandom_range(99) < vld_pct);
    if (stim_q.size() > 0) begin
      data_i = stim_q[0].w;
      sop_i  = stim_q[0].sop;
      eop_i  = stim_q[0].eop;
    end else begin
      data_i = {$urandom, $urandom};
      sop_i  = 1'b0;
      eop_i  = 1'b0;
    end
    ready_i = ($urandom_range(99) < rdy_pct);
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ready_i);
    check("valid_o", {63'b0, valid_o}, {63'b0, exp_q.size() > 0});
    check("ready_o", {63'b0, ready_o}, {63'b0, exp_rdy});
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("data_o", data_o, e.data);
      check("sop_eop_err", {61'b0, sop_o, eop_o, err_o}, {61'b0, e.sop, e.eop, e.err});
    end else begin
      check("idle_flags", {61'b0, sop_o, eop_o, err_o}, 64'd0);
    end
    if (stalled_prev && valid_o) check("stall_hold", data_o, prev_data);
    stalled_prev = valid_o && !ready_i && !do_rst;
    prev_data    = data_o;
    if (do_rst) begin
      exp_q.delete();
      m_in_pkt = 0;
      m_idx    = 0;
      m_err    = 0;
    end else begin
      take = (exp_q.size() > 0) && ready_i;
      acc  = valid_i && exp_rdy;
      if (take) begin
        void'(exp_q.pop_front());
        got_log.push_back('{data_o, sop_o, eop_o, err_o});
        got_cyc.push_back(cyc);
      end
      if (acc) model_accept(stim_q.pop_front());
    end
    cyc++;
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    check("drain_timeout", 64'(stim_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic add_pkt(input logic [63:0] w0, input int len, input bit with_eop, input bit zeros);
    word_t wd;
    for (int i = 0; i < len; i++) begin
      wd.w   = (i == 0) ? w0 : (zeros ? 64'd0 : {$urandom, $urandom});
      wd.sop = (i == 0);
      wd.eop = with_eop && (i == len - 1);
      stim_q.push_back(wd);
    end
  endtask

  task automatic clear_log();
    got_log.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [63:0] w;
    int          n;
    int          nz;
    word_t       sw;

    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid_o", {63'b0, valid_o}, 64'd0);
    check("rst_ready_o", {63'b0, ready_o}, 64'd1);
    check("rst_flags", {61'b0, sop_o, eop_o, err_o}, 64'd0);

    // Clean packet, continuous flow.
    vld_pct = 100; rdy_pct = 100; clear_log();
    add_pkt(64'h8123_4567_89AB_CDEF, 16, 1, 1);
    run_drain(200);
    check("t1_count", 64'(got_log.size()), 64'd32);
    if (got_log.size() == 32) begin
      check("t1_beat0", got_log[0].data, 64'h0001_0023_0045_0067);
      check("t1_beat1", got_log[1].data, 64'hFF89_FFAB_FFCD_FFEF);
      check("t1_sop0", {63'b0, got_log[0].sop}, 64'd1);
      check("t1_eop31", {62'b0, got_log[31].eop, got_log[31].err}, 64'd2);
      nz = 0;
      for (int i = 2; i < 32; i++) if (got_log[i].data != 64'd0) nz++;
      check("t1_zero_beats", 64'(nz), 64'd0);
      check("t1_back_to_back", 64'(got_cyc[31] - got_cyc[0]), 64'd31);
    end

    // Header lane sign extension from 7 bits.
    clear_log();
    add_pkt(64'hFF80_7F01_0000_0000, 16, 1, 1);
    run_drain(200);
    check("t2_beat0", got_log.size() > 0 ? got_log[0].data : 64'hX, 64'hFFFF_FF80_007F_0001);

    // Same packet under random backpressure.
    rdy_pct = 50; clear_log();
    add_pkt(64'hFF80_7F01_0000_0000, 16, 1, 1);
    run_drain(1000);
    check("t3_count", 64'(got_log.size()), 64'd32);

    // Missing marker bit.
    rdy_pct = 100; clear_log();
    add_pkt(64'h0123_4567_89AB_CDEF, 16, 1, 0);
    run_drain(200);
    check("t4_count", 64'(got_log.size()), 64'd32);
    if (got_log.size() == 32) check("t4_err", {62'b0, got_log[31].eop, got_log[31].err}, 64'd3);

    // Short packet: eop on word 9.
    clear_log();
    add_pkt(64'h8000_0000_0000_0000 | {$urandom, $urandom}, 10, 1, 0);
    run_drain(200);
    check("t5_count", 64'(got_log.size()), 64'd20);
    if (got_log.size() == 20) check("t5_err", {62'b0, got_log[19].eop, got_log[19].err}, 64'd3);

    // Stray non-sop word while idle.
    clear_log();
    sw.w = {$urandom, $urandom}; sw.sop = 1'b0; sw.eop = 1'b0;
    stim_q.push_back(sw);
    run_drain(50);
    repeat (3) step(1'b0);
    check("t5_stray", 64'(got_log.size()), 64'd0);

    // Reset while the lower half of word 7 is pending.
    add_pkt(64'h8000_0000_0000_0000 | {$urandom, $urandom}, 16, 1, 0);
    n = 0;
    while (!(m_in_pkt && m_idx == 7 && exp_q.size() == 1) && n < 200) begin
      step(1'b0);
      n++;
    end
    check("t6_reach_lower", {63'b0, (m_in_pkt && m_idx == 7 && exp_q.size() == 1)}, 64'd1);
    step(1'b1);
    stim_q.delete();
    step(1'b0);
    check("t6_valid_after_rst", {63'b0, valid_o}, 64'd0);
    check("t6_ready_after_rst", {63'b0, ready_o}, 64'd1);
    clear_log();
    add_pkt(64'h8000_0000_0000_0000 | {$urandom, $urandom}, 16, 1, 0);
    run_drain(200);
    check("t6_count", 64'(got_log.size()), 64'd32);
    if (got_log.size() == 32) check("t6_err", {62'b0, got_log[31].eop, got_log[31].err}, 64'd2);

    // Randomized traffic with mixed packet shapes.
    for (int p = 0; p < 40; p++) begin
      vld_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      w = {$urandom, $urandom};
      case ($urandom_range(4))
        0: add_pkt(w | 64'h8000_0000_0000_0000, 16, 1, 0);
        1: add_pkt(w & 64'h7FFF_FFFF_FFFF_FFFF, 16, 1, 0);
        2: add_pkt(w | 64'h8000_0000_0000_0000, $urandom_range(15, 1), 1, 0);
        3: add_pkt(w | 64'h8000_0000_0000_0000, $urandom_range(15, 1), 0, 0);
        default: begin
          sw.w = w; sw.sop = 1'b0; sw.eop = 1'b0;
          stim_q.push_back(sw);
        end
      endcase
      run_drain(2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
